// File: rtl/uparc_fwdu_sb.sv
//============================================================================
// Module   : uparc_fwdu_sb
// Brief    : Decode-stage operand forwarding unit with a long-latency
//            scoreboard, interlock generation and a saturating stall counter.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module uparc_fwdu_sb #(
   parameter int REG_WIDTH   = 32,
   parameter int REGNO_WIDTH = 5,
   parameter int NSRC        = 2,
   parameter int LOAD_DELAY  = 1,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [REGNO_WIDTH-1:0]      rs,
   input  logic [REG_WIDTH-1:0]        rs_data,
   input  logic [REGNO_WIDTH-1:0]      rt,
   input  logic [REG_WIDTH-1:0]        rt_data,
   input  logic [NSRC*REGNO_WIDTH-1:0] src_rd,
   input  logic [NSRC*REG_WIDTH-1:0]   src_data,
   input  logic [NSRC-1:0]             src_valid,
   input  logic                        lg_issue,
   input  logic [REGNO_WIDTH-1:0]      lg_rd,
   input  logic                        lg_wb,
   input  logic [REGNO_WIDTH-1:0]      lg_wb_rd,
   input  logic [REG_WIDTH-1:0]        lg_wb_data,
   input  logic                        cnt_clr,
   output logic [REG_WIDTH-1:0]        rs_data_p1,
   output logic [REG_WIDTH-1:0]        rt_data_p1,
   output logic                        stall,
   output logic                        lg_pending,
   output logic [CNT_WIDTH-1:0]        stall_cnt
);

   localparam int c_nreg = 2 ** REGNO_WIDTH;

   logic [c_nreg-1:1]    r_busy;
   logic                 r_lg_pending;
   logic [CNT_WIDTH-1:0] r_stall_cnt;

   logic [c_nreg-1:0]    w_busy_full;
   logic [c_nreg-1:0]    w_busy_nxt;
   logic [REG_WIDTH:0]   w_rs_res;
   logic [REG_WIDTH:0]   w_rt_res;
   logic                 w_waw;
   logic                 w_stall;
   logic                 w_set;

   // Register 0 has no scoreboard entry; it reads as permanently idle.
   assign w_busy_full = {r_busy, 1'b0};

   // Returns {hazard, value}. Source 0 is the youngest, so the first hit wins.
   function automatic logic [REG_WIDTH:0] resolve(
      input logic [REGNO_WIDTH-1:0] rn,
      input logic [REG_WIDTH-1:0]   rf,
      input logic [c_nreg-1:0]      busy
   );
      logic                 found;
      logic                 hz;
      logic [REG_WIDTH-1:0] val;
      found = 1'b0;
      hz    = 1'b0;
      val   = rf;
      if (rn != '0) begin
         for (int i = 0; i < NSRC; i++) begin
            if (!found && src_rd[i*REGNO_WIDTH +: REGNO_WIDTH] == rn) begin
               if (src_valid[i]) begin
                  found = 1'b1;
                  val   = src_data[i*REG_WIDTH +: REG_WIDTH];
               end else if (LOAD_DELAY == 0) begin
                  found = 1'b1;
                  hz    = 1'b1;
               end
            end
         end
         if (!found) begin
            if (lg_wb && lg_wb_rd == rn)
               val = lg_wb_data;
            else if (busy[rn])
               hz = 1'b1;
         end
      end
      return {hz, val};
   endfunction

   always_comb begin
      w_rs_res = resolve(rs, rs_data, w_busy_full);
      w_rt_res = resolve(rt, rt_data, w_busy_full);
   end

   // A writeback to the same register this cycle retires the older op in time.
   assign w_waw   = lg_issue && (lg_rd != '0) && w_busy_full[lg_rd]
                    && !(lg_wb && lg_wb_rd == lg_rd);
   assign w_stall = w_rs_res[REG_WIDTH] | w_rt_res[REG_WIDTH] | w_waw;
   assign w_set   = lg_issue && !w_stall && (lg_rd != '0);

   // Clear first, then set, so a same-register set/clear race keeps the bit.
   always_comb begin
      w_busy_nxt = w_busy_full;
      if (lg_wb)
         w_busy_nxt[lg_wb_rd] = 1'b0;
      if (w_set)
         w_busy_nxt[lg_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy       <= '0;
         r_lg_pending <= 1'b0;
         r_stall_cnt  <= '0;
      end else begin
         r_busy       <= w_busy_nxt[c_nreg-1:1];
         r_lg_pending <= |w_busy_nxt;
         if (cnt_clr)
            r_stall_cnt <= '0;
         else if (w_stall && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign rs_data_p1 = w_rs_res[REG_WIDTH-1:0];
   assign rt_data_p1 = w_rt_res[REG_WIDTH-1:0];
   assign stall      = w_stall;
   assign lg_pending = r_lg_pending;
   assign stall_cnt  = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_uparc_fwdu_sb.sv
//============================================================================
// Module   : tb_uparc_fwdu_sb
// Brief    : Directed self-checking bench; instance a skips pending loads,
//            instance b interlocks on them and has a narrow stall counter.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_uparc_fwdu_sb;

   logic        clk;
   logic        rst;
   logic [4:0]  rs, rt, lg_rd, lg_wb_rd;
   logic [31:0] rs_data, rt_data, lg_wb_data;
   logic [9:0]  src_rd;
   logic [63:0] src_data;
   logic [1:0]  src_valid;
   logic        lg_issue, lg_wb, cnt_clr;

   logic [31:0] rs_p1_a, rt_p1_a, rs_p1_b, rt_p1_b;
   logic        stall_a, stall_b, pend_a, pend_b;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;

   int checks   = 0;
   int failures = 0;

   uparc_fwdu_sb dut_a (
      .clk(clk), .rst(rst), .rs(rs), .rs_data(rs_data), .rt(rt), .rt_data(rt_data),
      .src_rd(src_rd), .src_data(src_data), .src_valid(src_valid),
      .lg_issue(lg_issue), .lg_rd(lg_rd), .lg_wb(lg_wb), .lg_wb_rd(lg_wb_rd),
      .lg_wb_data(lg_wb_data), .cnt_clr(cnt_clr),
      .rs_data_p1(rs_p1_a), .rt_data_p1(rt_p1_a), .stall(stall_a),
      .lg_pending(pend_a), .stall_cnt(cnt_a)
   );

   uparc_fwdu_sb #(.LOAD_DELAY(0), .CNT_WIDTH(4)) dut_b (
      .clk(clk), .rst(rst), .rs(rs), .rs_data(rs_data), .rt(rt), .rt_data(rt_data),
      .src_rd(src_rd), .src_data(src_data), .src_valid(src_valid),
      .lg_issue(lg_issue), .lg_rd(lg_rd), .lg_wb(lg_wb), .lg_wb_rd(lg_wb_rd),
      .lg_wb_data(lg_wb_data), .cnt_clr(cnt_clr),
      .rs_data_p1(rs_p1_b), .rt_data_p1(rt_p1_b), .stall(stall_b),
      .lg_pending(pend_b), .stall_cnt(cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs = 5'd0; rs_data = 32'h0; rt = 5'd0; rt_data = 32'h0;
      src_rd = '0; src_data = '0; src_valid = '0;
      lg_issue = 1'b0; lg_rd = 5'd0; lg_wb = 1'b0; lg_wb_rd = 5'd0;
      lg_wb_data = 32'h0; cnt_clr = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      lg_issue = 1'b1; lg_rd = 5'd7;
      step(); step();
      rst = 1'b0;
      idle();
      rs = 5'd7; rs_data = 32'hCAFE0007;
      #1;
      checks++; if (pend_a !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", pend_a); end
      checks++; if (cnt_a !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt_a); end
      checks++; if (rs_p1_a !== 32'hCAFE0007) begin failures++; $display("FAIL reset_rs got=%h exp=cafe0007", rs_p1_a); end
      checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL reset_issue_discard stall got=%b exp=0", stall_a); end
   endtask

   task automatic test_forward();
      idle();
      rs = 5'd5; rs_data = 32'h5555; rt = 5'd5; rt_data = 32'h6666;
      src_rd = {5'd5, 5'd5}; src_valid = 2'b11; src_data = {32'hAA, 32'hBB};
      #1;
      checks++; if (rs_p1_a !== 32'hBB) begin failures++; $display("FAIL fwd_youngest got=%h exp=bb", rs_p1_a); end
      checks++; if (rt_p1_b !== 32'hBB) begin failures++; $display("FAIL fwd_youngest_rt got=%h exp=bb", rt_p1_b); end
      checks++; if (stall_a !== 1'b0 || stall_b !== 1'b0) begin failures++; $display("FAIL fwd_stall got=%b%b exp=00", stall_a, stall_b); end
      src_rd = {5'd5, 5'd3};
      #1;
      checks++; if (rs_p1_a !== 32'hAA) begin failures++; $display("FAIL fwd_older got=%h exp=aa", rs_p1_a); end
      rs = 5'd0; rs_data = 32'h77; src_rd = '0;
      lg_wb = 1'b1; lg_wb_rd = 5'd0; lg_wb_data = 32'hDEAD;
      #1;
      checks++; if (rs_p1_a !== 32'h77) begin failures++; $display("FAIL fwd_reg0 got=%h exp=77", rs_p1_a); end
   endtask

   task automatic test_load_delay();
      idle();
      rt = 5'd7; rt_data = 32'h7070;
      src_rd = {5'd7, 5'd7}; src_valid = 2'b10; src_data = {32'h11, 32'h99};
      #1;
      checks++; if (rt_p1_a !== 32'h11) begin failures++; $display("FAIL ld_skip got=%h exp=11", rt_p1_a); end
      checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL ld_skip_stall got=%b exp=0", stall_a); end
      checks++; if (stall_b !== 1'b1) begin failures++; $display("FAIL ld_interlock got=%b exp=1", stall_b); end
      step();
      checks++; if (cnt_b !== 4'd1) begin failures++; $display("FAIL ld_cnt got=%0d exp=1", cnt_b); end
      checks++; if (cnt_a !== 16'd0) begin failures++; $display("FAIL ld_cnt_a got=%0d exp=0", cnt_a); end
      cnt_clr = 1'b1;
      step();
      checks++; if (cnt_b !== 4'd0) begin failures++; $display("FAIL cnt_clr_priority got=%0d exp=0", cnt_b); end
      cnt_clr = 1'b0;
      src_rd = {5'd2, 5'd7};
      #1;
      checks++; if (rt_p1_a !== 32'h7070) begin failures++; $display("FAIL ld_skip_rf got=%h exp=7070", rt_p1_a); end
   endtask

   task automatic test_scoreboard();
      idle();
      lg_issue = 1'b1; lg_rd = 5'd9;
      #1;
      checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL sb_issue_stall got=%b exp=0", stall_a); end
      step();
      lg_issue = 1'b0;
      checks++; if (pend_a !== 1'b1) begin failures++; $display("FAIL sb_pending_set got=%b exp=1", pend_a); end
      rs = 5'd9; rs_data = 32'h55;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (stall_a !== 1'b1) begin failures++; $display("FAIL sb_raw_stall cyc=%0d got=%b exp=1", k, stall_a); end
         step();
      end
      checks++; if (cnt_a !== 16'd3) begin failures++; $display("FAIL sb_cnt got=%0d exp=3", cnt_a); end
      lg_wb = 1'b1; lg_wb_rd = 5'd9; lg_wb_data = 32'h1234;
      #1;
      checks++; if (rs_p1_a !== 32'h1234) begin failures++; $display("FAIL sb_bypass got=%h exp=1234", rs_p1_a); end
      checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL sb_bypass_stall got=%b exp=0", stall_a); end
      step();
      lg_wb = 1'b0;
      #1;
      checks++; if (pend_a !== 1'b0) begin failures++; $display("FAIL sb_pending_clr got=%b exp=0", pend_a); end
      checks++; if (rs_p1_a !== 32'h55 || stall_a !== 1'b0) begin failures++; $display("FAIL sb_after_wb got=%h/%b exp=55/0", rs_p1_a, stall_a); end
   endtask

   task automatic test_waw_race();
      idle();
      lg_issue = 1'b1; lg_rd = 5'd3;
      step();
      #1;
      checks++; if (stall_a !== 1'b1) begin failures++; $display("FAIL waw_stall got=%b exp=1", stall_a); end
      lg_wb = 1'b1; lg_wb_rd = 5'd3;
      #1;
      checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL race_stall got=%b exp=0", stall_a); end
      step();
      idle();
      rs = 5'd3; rs_data = 32'h33;
      #1;
      checks++; if (pend_a !== 1'b1) begin failures++; $display("FAIL race_set_wins pending got=%b exp=1", pend_a); end
      checks++; if (stall_a !== 1'b1) begin failures++; $display("FAIL race_busy3 stall got=%b exp=1", stall_a); end
      rs = 5'd0; lg_wb = 1'b1; lg_wb_rd = 5'd3;
      step();
      lg_wb_rd = 5'd12;
      step();
      lg_wb = 1'b0;
      #1;
      checks++; if (pend_a !== 1'b0) begin failures++; $display("FAIL wb_nonbusy pending got=%b exp=0", pend_a); end
   endtask

   task automatic test_saturation();
      idle();
      lg_issue = 1'b1; lg_rd = 5'd4;
      step();
      lg_issue = 1'b0;
      rs = 5'd6; rs_data = 32'h66; src_rd = {5'd0, 5'd6}; src_valid = 2'b00;
      for (int k = 0; k < 21; k++) step();
      checks++; if (cnt_b !== 4'hF) begin failures++; $display("FAIL sat_cnt got=%0d exp=15", cnt_b); end
      checks++; if (pend_a !== 1'b1 || pend_b !== 1'b1) begin failures++; $display("FAIL sat_pending got=%b%b exp=11", pend_a, pend_b); end
      checks++; if (stall_a !== 1'b0 || rs_p1_a !== 32'h66) begin failures++; $display("FAIL sat_skip got=%b/%h exp=0/66", stall_a, rs_p1_a); end
      rst = 1'b1; lg_issue = 1'b1; lg_rd = 5'd8;
      step();
      rst = 1'b0;
      idle();
      rs = 5'd4; rs_data = 32'h44;
      #1;
      checks++; if (cnt_b !== 4'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", cnt_b); end
      checks++; if (pend_a !== 1'b0 || pend_b !== 1'b0) begin failures++; $display("FAIL rst_pending got=%b%b exp=00", pend_a, pend_b); end
      checks++; if (rs_p1_a !== 32'h44 || stall_a !== 1'b0) begin failures++; $display("FAIL rst_rs4 got=%h/%b exp=44/0", rs_p1_a, stall_a); end
      rs = 5'd8;
      #1;
      checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL rst_issue_discard got=%b exp=0", stall_a); end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_forward();
      test_load_delay();
      test_scoreboard();
      test_waw_race();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uparc_fwdu_sb.md
UPARC_FWDU_SB -- requirements
Module: uparc_fwdu_sb

Interface
REQ-001 The block SHALL use one clock `clk`, and reset SHALL be synchronous and active-high on `rst`.
REQ-002 Parameters SHALL be, one per line (name, default, meaning):
- REG_WIDTH, 32, register data width.
- REGNO_WIDTH, 5, register-number width; register count is 2^REGNO_WIDTH.
- NSRC, 2, number of pipeline forwarding sources (1..4); index 0 is the youngest.
- LOAD_DELAY, 1, invalid-source policy: 1 = skip and search older sources; 0 = interlock (stall).
- CNT_WIDTH, 16, stall-counter width.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- rs, in, REGNO_WIDTH, decode-stage source register A.
- rs_data, in, REG_WIDTH, register-file value of rs.
- rt, in, REGNO_WIDTH, decode-stage source register B.
- rt_data, in, REG_WIDTH, register-file value of rt.
- src_rd, in, NSRC*REGNO_WIDTH, destination of each source; slice i = source i.
- src_data, in, NSRC*REG_WIDTH, result of each source.
- src_valid, in, NSRC, source result is available this cycle (0 = pending load).
- lg_issue, in, 1, decode is issuing a long-latency op (mul/div).
- lg_rd, in, REGNO_WIDTH, destination of the issued long-latency op.
- lg_wb, in, 1, a long-latency result is written back this cycle.
- lg_wb_rd, in, REGNO_WIDTH, destination of that writeback.
- lg_wb_data, in, REG_WIDTH, data of that writeback.
- cnt_clr, in, 1, clear the stall counter.
- rs_data_p1, out, REG_WIDTH, forwarded rs value.
- rt_data_p1, out, REG_WIDTH, forwarded rt value.
- stall, out, 1, decode must hold this cycle.
- lg_pending, out, 1, at least one scoreboard bit is set.
- stall_cnt, out, CNT_WIDTH, saturating count of stalled cycles.

Function
REQ-004 Register 0 SHALL never match any source, never be busy, and always yield rs_data/rt_data unchanged.
REQ-005 Operand resolution (identical for rs and rt) SHALL scan sources 0..NSRC-1 in order; the first source with a matching non-zero src_rd SHALL be selected.
REQ-006 If the selected source has src_valid=1, the operand SHALL equal its src_data.
REQ-007 If the selected source has src_valid=0 and LOAD_DELAY=1, that source SHALL be skipped and the scan SHALL continue with older sources, then the lg bypass, then the register file; no stall SHALL result.
REQ-008 If the selected source has src_valid=0 and LOAD_DELAY=0, stall SHALL be asserted, and the operand value is don't-care.
REQ-009 If no source matches, the operand SHALL equal lg_wb_data when lg_wb=1 and lg_wb_rd equals the operand; otherwise it SHALL equal the register-file value.
REQ-010 If no source matches, the operand's busy bit is set, and there is no same-cycle lg_wb bypass for it, stall SHALL be asserted.
REQ-011 stall SHALL also assert on lg_issue=1 with lg_rd≠0 when busy[lg_rd]=1 and lg_wb does not clear that same register this cycle (WAW).
REQ-012 Operand muxes and stall SHALL be purely combinational: zero-cycle latency from the inputs.
REQ-013 Scoreboard busy[2^REGNO_WIDTH-1:1] SHALL be registered.
REQ-014 On lg_wb=1, busy[lg_wb_rd] SHALL be cleared at the next edge.
REQ-015 On lg_issue=1, stall=0 and lg_rd≠0, busy[lg_rd] SHALL be set at the next edge.
REQ-016 When a set and a clear target the same register in one cycle, the set SHALL win.
REQ-017 An lg_issue seen while stall=1 SHALL be ignored, and the issuer SHALL hold it until stall=0.
REQ-018 lg_wb to a non-busy register SHALL be harmless: the bit stays 0.
REQ-019 lg_pending SHALL be the registered OR of all busy bits, reflecting state after the edge.
REQ-020 stall_cnt SHALL increment by 1 at each edge where stall=1.
REQ-021 stall_cnt SHALL saturate at all-ones; it SHALL NOT wrap.
REQ-022 cnt_clr SHALL zero stall_cnt at the next edge and SHALL take priority over the increment.

Reset
REQ-023 While rst=1 at an edge, all busy bits SHALL clear, lg_pending SHALL be 0, and stall_cnt SHALL be 0.
REQ-024 An lg_issue presented in a reset cycle SHALL be discarded.
REQ-025 Combinational outputs SHALL follow REQ-005..011 using the cleared state.
REQ-026 A reset mid-operation SHALL drop all pending scoreboard entries without generating writebacks.

Verification
REQ-027 NSRC=2: rs=5, src_rd={5,5}, valid={1,1}, data={0xAA,0xBB} -> rs_data_p1=0xBB (source 0), stall=0.
REQ-028 LOAD_DELAY=1: rt=7, src0 rd=7 valid=0, src1 rd=7 data=0x11 -> rt_data_p1=0x11, stall=0.
REQ-029 LOAD_DELAY=0: same stimulus as REQ-028 -> stall=1, and stall_cnt increments by 1 after the edge.
REQ-030 lg_issue rd=9, then rs=9 with no source match -> stall=1 each cycle; lg_wb rd=9 data=0x1234 -> same cycle rs_data_p1=0x1234, stall=0; next cycle lg_pending=0.
REQ-031 Set/clear race: busy[3]=1, lg_wb rd=3 with lg_issue rd=3 in one cycle -> stall=0, busy[3] remains 1.
REQ-032 Saturation/reset: force stall for 2^CNT_WIDTH+5 cycles -> stall_cnt=all-ones; assert rst with busy[4]=1 -> stall_cnt=0, lg_pending=0, rs=4 yields rs_data with stall=0.
